// File: rtl/alu_iter_pkg.sv
// ---------------------------------------------------------------------------
// alu_iter_pkg
// Shared definitions for the iterative multiply/shift unit:
//   - opcode constants (MUL, SLL, SRL, SRA, ROR; anything else is illegal)
//   - FSM state encoding for the control sequencer
//   - step-count limit, which is also the default operand width
// ---------------------------------------------------------------------------
package alu_iter_pkg;

  localparam int STEP_LIMIT = 8;

  localparam logic [2:0] OP_MUL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  // Opcodes above ROR have no operation behind them.
  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_ROR;
  endfunction

endpackage

// File: rtl/alu_iter_step.sv
// ---------------------------------------------------------------------------
// alu_iter_step
// Purely combinational single iteration of the unit.
//   op_i   : latched opcode
//   acc_i  : current accumulator (partial product or value being shifted)
//   opa_i  : multiplicand, pre-shifted to the current bit weight (MUL only)
//   opb_i  : remaining multiplier bits, LSB is the bit consumed now (MUL only)
//   acc_o / opa_o / opb_o : values after one step
// MUL is shift-and-add: the multiplicand moves left while the multiplier
// moves right, so bit 0 of opb always selects the current partial product.
// Only the low WIDTH bits are kept, which yields the truncated product.
// ---------------------------------------------------------------------------
import alu_iter_pkg::*;

module alu_iter_step #(
  parameter int WIDTH = STEP_LIMIT
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] opa_o,
  output logic [WIDTH-1:0] opb_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    acc_o = acc_i;
    opa_o = opa_i;
    opb_o = opb_i;
    case (op_i)
      OP_MUL: begin
        if (opb_i[0]) acc_o = acc_i + opa_i;
        opa_o = opa_i << 1;
        opb_o = opb_i >> 1;
      end
      OP_SLL:  acc_o = acc_i << 1;
      OP_SRL:  acc_o = acc_i >> 1;
      OP_SRA:  acc_o = {acc_i[WIDTH-1], acc_i[WIDTH-1:1]};
      OP_ROR:  acc_o = {acc_i[0], acc_i[WIDTH-1:1]};
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_iter_unit.sv
// ---------------------------------------------------------------------------
// alu_iter_unit
// Iterative multiply / shift unit, one step per clock.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   start_i  : operation request, only looked at in IDLE
//   opcode_i : 000 MUL, 001 SLL, 010 SRL, 011 SRA, 100 ROR, others illegal
//   data1_i  : multiplicand / value to shift
//   data2_i  : multiplier / shift amount
//   result_o : result of the last completed operation (held between DONEs)
//   busy_o   : high in RUN and FIN
//   done_o   : one-cycle pulse, coincident with result_o update
// Timing: accepted at edge k, RUN lasts max(N,1) cycles, one FIN cycle,
// result and done appear after edge k+max(N,1)+1.
// ---------------------------------------------------------------------------
import alu_iter_pkg::*;

module alu_iter_unit #(
  parameter int WIDTH = STEP_LIMIT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       opcode_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH[WIDTH-1:0];

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] acc_s, a_s, b_s;

  // Number of RUN steps that do work; shifts saturate at WIDTH (all bits
  // gone), rotates wrap modulo WIDTH.
  function automatic logic [CW-1:0] step_count(input logic [2:0]       op,
                                               input logic [WIDTH-1:0] d2);
    logic [CW-1:0] n;
    n = '0;
    case (op)
      OP_MUL:                 n = CW'(WIDTH);
      OP_SLL, OP_SRL, OP_SRA: n = (d2 >= WIDTH_V) ? CW'(WIDTH) : CW'(d2);
      OP_ROR:                 n = CW'(d2 % WIDTH_V);
      default:                n = '0;
    endcase
    return n;
  endfunction

  alu_iter_step #(.WIDTH(WIDTH)) u_step (
    .op_i  (op_q),
    .acc_i (acc_q),
    .opa_i (a_q),
    .opb_i (b_q),
    .acc_o (acc_s),
    .opa_o (a_s),
    .opb_o (b_s)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          op_d    = opcode_i;
          a_d     = data1_i;
          b_d     = data2_i;
          cnt_d   = step_count(opcode_i, data2_i);
          // Products accumulate from zero; illegal ops must also end at zero.
          acc_d   = (opcode_i == OP_MUL || !op_is_legal(opcode_i)) ? '0 : data1_i;
        end
      end
      S_RUN: begin
        // A zero count still costs one RUN cycle, with the accumulator idle.
        if (cnt_q != '0) begin
          acc_d = acc_s;
          a_d   = a_s;
          b_d   = b_s;
          cnt_d = cnt_q - 1'b1;
        end
        if (cnt_q <= CW'(1)) state_d = S_FIN;
      end
      S_FIN: begin
        state_d  = S_IDLE;
        result_d = acc_q;
        done_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; every register, operands included, is reset so an
  // aborted operation leaves nothing behind.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign result_o = result_q;
  assign done_o   = done_q;
  assign busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_iter_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_iter_unit
// Self-checking bench for alu_iter_unit (WIDTH = 8). A transaction-level
// model computes each result with plain arithmetic and the completion time
// from the step count; a compare process checks busy/done/result every
// falling edge. Directed cases pin exact results and latencies.
// ---------------------------------------------------------------------------
module tb_alu_iter_unit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] opcode;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [7:0] result;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  alu_iter_unit #(.WIDTH(8)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .opcode_i (opcode),
    .data1_i  (data1),
    .data2_i  (data2),
    .result_o (result),
    .busy_o   (busy),
    .done_o   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_result(input logic [2:0] op,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
    int         p;
    int         r;
    logic [7:0] res;
    res = 8'h00;
    case (op)
      3'd0: begin p = int'(a) * int'(b); res = p[7:0]; end
      3'd1: res = (b >= 8) ? 8'h00 : (a << b);
      3'd2: res = (b >= 8) ? 8'h00 : (a >> b);
      3'd3: res = (b >= 8) ? {8{a[7]}} : 8'($signed(a) >>> b);
      3'd4: begin r = int'(b) % 8; res = (a >> r) | (a << (8 - r)); end
      default: res = 8'h00;
    endcase
    return res;
  endfunction

  // Edges from acceptance until result/done appear.
  function automatic int ref_latency(input logic [2:0] op, input logic [7:0] b);
    int n;
    case (op)
      3'd0:             n = 8;
      3'd1, 3'd2, 3'd3: n = (b >= 8) ? 8 : int'(b);
      3'd4:             n = int'(b) % 8;
      default:          n = 0;
    endcase
    return ((n < 1) ? 1 : n) + 1;
  endfunction

  logic [7:0] m_result, m_pending;
  logic       m_busy, m_done;
  int         m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_result  <= 8'h00;
      m_pending <= 8'h00;
      m_busy    <= 1'b0;
      m_done    <= 1'b0;
      m_left    <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_result <= m_pending;
          m_done   <= 1'b1;
          m_busy   <= 1'b0;
        end
      end else if (start) begin
        m_pending <= ref_result(opcode, data1, data2);
        m_left    <= ref_latency(opcode, data2);
        m_busy    <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en && rst_n) begin
      check("busy", int'(busy), int'(m_busy));
      check("done", int'(done), int'(m_done));
      check("result", int'(result), int'(m_result));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_res, input int exp_lat);
    int cyc;
    @(negedge clk);
    start = 1'b1; opcode = op; data1 = a; data2 = b;
    @(posedge clk);
    #1;
    start = 1'b0; data1 = $urandom; data2 = $urandom; opcode = 3'($urandom);
    cyc = 0;
    while (cyc < 30) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) break;
    end
    check({name, "_latency"}, cyc, exp_lat);
    check({name, "_result"}, int'(result), int'(exp_res));
  endtask

  int dcount;

  initial begin
    rst_n = 1'b0; start = 1'b0; opcode = 3'd0; data1 = 8'h00; data2 = 8'h00;
    #13;
    check("reset_result", int'(result), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    // Release at a falling edge so the very next rising edge may accept.
    @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;
    start = 1'b1; opcode = 3'd0; data1 = 8'd13; data2 = 8'd11;
    @(posedge clk);
    #1;
    check("first_edge_accept_busy", int'(busy), 1);
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(posedge clk); #1; dcount++;
    end
    check("mul13x11_latency", dcount, 9);
    check("mul13x11_result", int'(result), 8'h8F);

    run_op("mul20x20", 3'd0, 8'd20, 8'd20, 8'h90, 9);
    run_op("sra3", 3'd3, 8'h90, 8'd3, 8'hF2, 4);
    run_op("sra9", 3'd3, 8'h90, 8'd9, 8'hFF, 9);
    run_op("sll8", 3'd1, 8'hA5, 8'd8, 8'h00, 9);
    run_op("ror9", 3'd4, 8'h81, 8'd9, 8'hC0, 2);
    run_op("ror0", 3'd4, 8'h81, 8'd0, 8'h81, 2);
    run_op("illegal", 3'd6, 8'h5A, 8'd3, 8'h00, 2);
    run_op("srl0", 3'd2, 8'h3C, 8'd0, 8'h3C, 2);

    // Second start during RUN must be dropped.
    @(negedge clk);
    start = 1'b1; opcode = 3'd0; data1 = 8'd13; data2 = 8'd11;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; opcode = 3'd1; data1 = 8'hFF; data2 = 8'd1;
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("ignored_start_dones", dcount, 1);
    check("ignored_start_result", int'(result), 8'h8F);

    // Reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; opcode = 3'd0; data1 = 8'd200; data2 = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_result", int'(result), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("aborted_dones", dcount, 0);
    run_op("srl7", 3'd2, 8'h80, 8'd7, 8'h01, 8);

    // Random traffic, including held starts, ignored starts and resets.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 2) != 0);
      opcode = 3'($urandom_range(0, 7));
      data1  = 8'($urandom);
      data2  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_iter_unit.md
ALU_ITER_UNIT -- requirements
Module: alu_iter_unit

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand/result width; all values below assume 8.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RESET  input  1  SHALL be asynchronous, active-low (0 = reset).
REQ-004 START  input  1  SHALL request an operation; sampled only in IDLE.
REQ-005 OPCODE  input  3  SHALL select the operation: 000 MUL, 001 SLL, 010 SRL, 011 SRA, 100 ROR, others illegal.
REQ-006 DATA1  input  8  SHALL be the register operand (multiplicand / value shifted).
REQ-007 DATA2  input  8  SHALL be the immediate-or-register operand from the operand mux (multiplier / shift amount).
REQ-008 RESULT  output  8  SHALL carry the registered result of the last completed operation.
REQ-009 BUSY  output  1  SHALL be high while an accepted operation is in progress.
REQ-010 DONE  output  1  SHALL pulse high for exactly one cycle when RESULT is updated.

Function
REQ-011 FSM states IDLE, RUN, FIN; IDLE->RUN on rising edge with START=1; RUN->FIN when step counter reaches 0; FIN->IDLE unconditionally.
REQ-012 On acceptance, DATA1, DATA2, OPCODE SHALL be latched; later input changes SHALL NOT affect the operation.
REQ-013 Step count N: MUL 8; SLL/SRL/SRA min(DATA2,8); ROR DATA2 mod 8; illegal 0.
REQ-014 One step per RUN cycle: MUL = shift-and-add of one multiplier bit; shifts = one bit position.
REQ-015 N=0 SHALL spend one RUN cycle with no change; RESULT = DATA1 (illegal opcode: RESULT = 0).
REQ-016 MUL RESULT SHALL be the low 8 bits of the unsigned 16-bit product.
REQ-017 SLL/SRL with DATA2>=8 SHALL give 0; SRA with DATA2>=8 SHALL give all bits equal to DATA1[7].
REQ-018 Latency: acceptance at edge k; RESULT written and DONE=1 after edge k+max(N,1)+1; DONE cleared at next edge.
REQ-019 BUSY SHALL be 1 in RUN and FIN, 0 in IDLE; START while BUSY=1 SHALL be ignored (not queued).
REQ-020 START held high in FIN SHALL NOT be accepted until the following IDLE cycle.
REQ-021 RESULT SHALL hold its value between DONE pulses.

Reset
REQ-022 RESET=0 SHALL immediately force state IDLE, RESULT=0, BUSY=0, DONE=0, counter and operand registers 0.
REQ-023 Reset mid-operation SHALL abort it; no DONE pulse and no RESULT update for the aborted operation.
REQ-024 First START SHALL be accepted on the first rising edge with RESET=1.

Structure
REQ-025 Package alu_iter_pkg SHALL hold opcode constants, FSM state encoding and the step-count limit (8).
REQ-026 One combinational sub-module alu_iter_step SHALL compute a single MUL/shift step from accumulator, operands and opcode.
REQ-027 Counter, FSM and operand registers SHALL reside in alu_iter_unit.

Verification
REQ-028 MUL DATA1=13, DATA2=11 -> RESULT=0x8F, DONE 9 cycles after acceptance edge.
REQ-029 MUL DATA1=20, DATA2=20 -> RESULT=0x90 (truncated 400).
REQ-030 SRA DATA1=0x90, DATA2=3 -> RESULT=0xF2 after 3 RUN cycles; SRA DATA2=9 -> 0xFF; SLL DATA2=8 -> 0x00.
REQ-031 ROR DATA1=0x81, DATA2=9 -> RESULT=0xC0 (1 step); ROR DATA2=0 -> RESULT=0x81, DONE 2 cycles after acceptance.
REQ-032 START pulsed again during RUN with other operands -> ignored; only first operation's DONE; BUSY continuous.
REQ-033 RESET=0 asserted mid-MUL -> outputs 0 immediately, no DONE; fresh SRL 0x80 by 7 after release -> 0x01.
